// File: rtl/dtw_ref_loader.sv
// Reference-RAM writer for the DTW engine: drains packed samples from the src FIFO into
// the reference RAM, then reports a status word. Optional feature macro: DTW_REF_CHECKSUM_EN.
module dtw_ref_loader #(
  parameter int unsigned WIDTH            = 16,
  parameter int unsigned AXIS_WIDTH       = 32,
  parameter int unsigned REFMEM_PTR_WIDTH = 20
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rs,
  input  logic                        op_mode,
  input  logic [AXIS_WIDTH-1:0]       ref_len,
  output logic                        busy,
  output logic                        ref_load_done,
  output logic                        src_fifo_rden,
  input  logic                        src_fifo_empty,
  input  logic [31:0]                 src_fifo_data,
  output logic                        sink_fifo_wren,
  input  logic                        sink_fifo_full,
  output logic [31:0]                 sink_fifo_data,
  output logic                        sink_fifo_last,
  output logic                        wren_ref,
  output logic [REFMEM_PTR_WIDTH-1:0] addr_ref,
  output logic [WIDTH-1:0]            datain_ref
);

  localparam int unsigned CNT_W = REFMEM_PTR_WIDTH + 1;
  localparam logic [AXIS_WIDTH-1:0] MAX_LEN = AXIS_WIDTH'(64'd1 << REFMEM_PTR_WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, STATUS} state_t;

  state_t                        state_q, state_d;
  logic [CNT_W-1:0]              count_q, count_d;
  logic                          half_q, half_d;
  logic                          err_q, err_d;
  logic                          busy_d, done_d, wren_ref_d, sink_wren_d, sink_last_d;
  logic [REFMEM_PTR_WIDTH-1:0]   addr_d;
  logic [WIDTH-1:0]              datain_d;
  logic [31:0]                   sink_data_d;
  logic [WIDTH-1:0]              sample;
  logic                          last_smp;
  logic [31:0]                   status_word;
`ifdef DTW_REF_CHECKSUM_EN
  logic [WIDTH-1:0]              cks_q, cks_d;
  logic                          sel_q, sel_d;
`endif

  assign sample      = half_q ? src_fifo_data[2*WIDTH-1:WIDTH] : src_fifo_data[WIDTH-1:0];
  assign last_smp    = (AXIS_WIDTH'(count_q) + AXIS_WIDTH'(1)) == ref_len;
  assign status_word = {err_q, 31'(count_q)};

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    half_d        = half_q;
    err_d         = err_q;
    busy_d        = busy;
    done_d        = ref_load_done;
    wren_ref_d    = 1'b0;
    addr_d        = addr_ref;
    datain_d      = datain_ref;
    sink_wren_d   = 1'b0;
    sink_data_d   = sink_fifo_data;
    sink_last_d   = sink_fifo_last;
    src_fifo_rden = 1'b0;
`ifdef DTW_REF_CHECKSUM_EN
    cks_d         = cks_q;
    sel_d         = sel_q;
`endif
    case (state_q)
      IDLE: begin
        if (rs && op_mode) begin
          busy_d  = 1'b1;
          done_d  = 1'b0;
          count_d = '0;
          half_d  = 1'b0;
          err_d   = 1'b0;
`ifdef DTW_REF_CHECKSUM_EN
          cks_d   = '0;
          sel_d   = 1'b0;
`endif
          if (ref_len == '0 || ref_len > MAX_LEN) begin
            err_d   = 1'b1;
            state_d = STATUS;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (!src_fifo_empty) begin
          // Pop once both halves are used, or early on an odd final sample
          src_fifo_rden = half_q | last_smp;
          wren_ref_d    = 1'b1;
          addr_d        = count_q[REFMEM_PTR_WIDTH-1:0];
          datain_d      = sample;
          count_d       = count_q + CNT_W'(1);
          half_d        = ~half_q;
`ifdef DTW_REF_CHECKSUM_EN
          cks_d         = cks_q + sample;
`endif
          if (last_smp) state_d = STATUS;
        end
      end
      STATUS: begin
        if (!sink_fifo_full) begin
          sink_wren_d = 1'b1;
`ifdef DTW_REF_CHECKSUM_EN
          if (!sel_q) begin
            sink_data_d = status_word;
            sink_last_d = 1'b0;
            sel_d       = 1'b1;
          end else begin
            sink_data_d = {{(32-WIDTH){1'b0}}, cks_q};
            sink_last_d = 1'b1;
            state_d     = IDLE;
            busy_d      = 1'b0;
            done_d      = ~err_q;
          end
`else
          sink_data_d = status_word;
          sink_last_d = 1'b1;
          state_d     = IDLE;
          busy_d      = 1'b0;
          done_d      = ~err_q;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      count_q        <= '0;
      half_q         <= 1'b0;
      err_q          <= 1'b0;
      busy           <= 1'b0;
      ref_load_done  <= 1'b0;
      wren_ref       <= 1'b0;
      addr_ref       <= '0;
      datain_ref     <= '0;
      sink_fifo_wren <= 1'b0;
      sink_fifo_data <= '0;
      sink_fifo_last <= 1'b0;
`ifdef DTW_REF_CHECKSUM_EN
      cks_q          <= '0;
      sel_q          <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      half_q         <= half_d;
      err_q          <= err_d;
      busy           <= busy_d;
      ref_load_done  <= done_d;
      wren_ref       <= wren_ref_d;
      addr_ref       <= addr_d;
      datain_ref     <= datain_d;
      sink_fifo_wren <= sink_wren_d;
      sink_fifo_data <= sink_data_d;
      sink_fifo_last <= sink_last_d;
`ifdef DTW_REF_CHECKSUM_EN
      cks_q          <= cks_d;
      sel_q          <= sel_d;
`endif
    end
  end

endmodule
